// File: rtl/muldiv_seq.sv
// Sequential unsigned 16x16 multiply / 16/16 divide that time-shares the integer ALU; 16 RUN cycles plus one DONE cycle.
// No backpressure: start is taken only in IDLE and ignored while busy; done is a single-cycle pulse.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] alu_r,
    output logic [15:0] alu_s,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_y,
    input  logic        alu_c,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [15:0] result_hi,
    output logic [15:0] result_lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] OP_PASS_S = 4'b0000;
    localparam logic [3:0] OP_PASS_R = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_SUB    = 4'b0101;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] q_q, q_d;
    logic [15:0] opnd_q, opnd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        dbz_q, dbz_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] rem_shift;

    // Divide: partial remainder shifted left with the next dividend bit; acc[15] is the 17th bit.
    assign rem_shift = {acc_q[14:0], q_q[15]};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        dbz_d    = dbz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        alu_r    = 16'h0000;
        alu_s    = 16'h0000;
        alu_op   = OP_PASS_S;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = op;
                    opnd_d = b;
                    q_d    = a;
                    acc_d  = 16'h0000;
                    cnt_d  = 5'd0;
                    dbz_d  = 1'b0;
                    if (op && (b == 16'h0000)) begin
                        state_d  = S_DONE;
                        dbz_d    = 1'b1;
                        res_hi_d = a;
                        res_lo_d = 16'hFFFF;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                alu_s = opnd_q;
                if (!mode_q) begin
                    alu_r  = acc_q;
                    alu_op = q_q[0] ? OP_ADD : OP_PASS_R;
                    acc_d  = {alu_c, alu_y[15:1]};
                    q_d    = {alu_y[0], q_q[15:1]};
                end else begin
                    alu_r  = rem_shift;
                    alu_op = OP_SUB;
                    if (acc_q[15] || !alu_c) begin
                        acc_d = alu_y;
                        q_d   = {q_q[14:0], 1'b1};
                    end else begin
                        acc_d = rem_shift;
                        q_d   = {q_q[14:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                // Results are captured on entry to DONE so they are valid alongside the done pulse.
                if (cnt_q == 5'd15) begin
                    state_d  = S_DONE;
                    res_hi_d = acc_d;
                    res_lo_d = q_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= 16'h0000;
            q_q      <= 16'h0000;
            opnd_q   <= 16'h0000;
            cnt_q    <= 5'd0;
            mode_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_hi_q <= 16'h0000;
            res_lo_q <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            dbz_q    <= dbz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural combinational ALU attached to the ALU ports.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic [3:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_c;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [15:0] result_hi;
    logic [15:0] result_lo;

    int checks = 0;
    int errors = 0;

    muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .alu_r       (alu_r),
        .alu_s       (alu_s),
        .alu_op      (alu_op),
        .alu_y       (alu_y),
        .alu_c       (alu_c),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result_hi   (result_hi),
        .result_lo   (result_lo)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [16:0] wide;
        wide = 17'h0;
        case (alu_op)
            4'b0000: wide = {1'b0, alu_s};
            4'b0001: wide = {1'b0, alu_r};
            4'b0100: wide = {1'b0, alu_r} + {1'b0, alu_s};
            4'b0101: wide = {1'b0, alu_r} - {1'b0, alu_s};
            default: wide = 17'h0;
        endcase
        alu_y = wide[15:0];
        alu_c = wide[16];
    end

    // Drives a start for one edge; returns at the falling edge of the first cycle after acceptance.
    task automatic do_start(input logic o, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        op    = ~o;
    endtask

    // Counts cycles from the first cycle after acceptance (=1) until done; bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        #12;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/dbz=%b%b%b want 000", busy, done, div_by_zero);
        end
        checks++;
        if ({result_hi, result_lo} !== 32'h0) begin
            errors++;
            $display("FAIL reset_results: got %h_%h want 0000_0000", result_hi, result_lo);
        end
        checks++;
        if ({alu_r, alu_s, alu_op} !== 36'h0) begin
            errors++;
            $display("FAIL reset_alu: got r=%h s=%h op=%b want zeros", alu_r, alu_s, alu_op);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multiply;
        int cyc;
        do_start(1'b0, 16'h012C, 16'h00C8);
        checks++;
        if (alu_op !== 4'b0001) begin
            errors++;
            $display("FAIL mul_first_alu_op: got %b want 0001", alu_op);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 17", cyc);
        end
        checks++;
        if ({result_hi, result_lo, div_by_zero} !== {16'h0000, 16'hEA60, 1'b0}) begin
            errors++;
            $display("FAIL mul_300x200: got hi=%h lo=%h dbz=%b want 0000 EA60 0", result_hi, result_lo, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
        do_start(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done(cyc);
        checks++;
        if ({result_hi, result_lo} !== {16'hFFFE, 16'h0001}) begin
            errors++;
            $display("FAIL mul_ffff_sq: got hi=%h lo=%h want FFFE 0001", result_hi, result_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_divide;
        int cyc;
        do_start(1'b1, 16'd100, 16'd7);
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL div_latency: got %0d want 17", cyc);
        end
        checks++;
        if ({result_hi, result_lo} !== {16'h0002, 16'h000E}) begin
            errors++;
            $display("FAIL div_100_7: got rem=%h quo=%h want 0002 000E", result_hi, result_lo);
        end
        @(negedge clk);
        do_start(1'b1, 16'hFFFF, 16'h8001);
        wait_done(cyc);
        checks++;
        if ({result_hi, result_lo} !== {16'h7FFE, 16'h0001}) begin
            errors++;
            $display("FAIL div_top_bit: got rem=%h quo=%h want 7FFE 0001", result_hi, result_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero;
        int cyc;
        do_start(1'b1, 16'h1234, 16'h0000);
        wait_done(cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", cyc);
        end
        checks++;
        if ({div_by_zero, result_hi, result_lo} !== {1'b1, 16'h1234, 16'hFFFF}) begin
            errors++;
            $display("FAIL dbz_values: got dbz=%b hi=%h lo=%h want 1 1234 FFFF", div_by_zero, result_hi, result_lo);
        end
        @(negedge clk);
        checks++;
        if ({div_by_zero, busy} !== 2'b10) begin
            errors++;
            $display("FAIL dbz_hold: got dbz=%b busy=%b want 1 0", div_by_zero, busy);
        end
        do_start(1'b0, 16'd2, 16'd2);
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear: got %b want 0", div_by_zero);
        end
        wait_done(cyc);
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        do_start(1'b0, 16'h012C, 16'h00C8);
        for (int k = 1; k <= 17; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== (k == 17)) begin
                errors++;
                $display("FAIL busy_window cycle %0d: got busy=%b done=%b want 1 %b", k, busy, done, k == 17);
            end
            start = (k == 5);
            a     = 16'd7;
            b     = 16'd9;
            op    = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after: got %b want 0", busy);
        end
        checks++;
        if ({result_hi, result_lo} !== {16'h0000, 16'hEA60}) begin
            errors++;
            $display("FAIL ignored_start_result: got hi=%h lo=%h want 0000 EA60", result_hi, result_lo);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int seen;
        do_start(1'b0, 16'hFFFF, 16'hFFFF);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero, result_hi, result_lo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                     busy, done, div_by_zero, result_hi, result_lo);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
        end
        do_start(1'b0, 16'd3, 16'd5);
        wait_done(cyc);
        checks++;
        if ({result_hi, result_lo} !== {16'h0000, 16'h000F}) begin
            errors++;
            $display("FAIL mul_3x5_after_reset: got hi=%h lo=%h want 0000 000F", result_hi, result_lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle unsigned 16×16 multiply and 16/16 divide sequencer that time-shares the 16-bit integer ALU. Each RUN cycle it drives the ALU operand and opcode inputs and consumes the ALU's result and carry. It sits beside the integer datapath as the only ALU master during a multiply or divide. It uses shift-add for multiply and restoring division for divide, with a start/done handshake toward the control unit.

## Interface
- No parameters; width fixed at 16.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin operation; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide
- a  in  16  multiplicand / dividend, latched on accepted start
- b  in  16  multiplier / divisor, latched on accepted start
- alu_r  out  16  ALU R operand
- alu_s  out  16  ALU S operand
- alu_op  out  4  ALU opcode: 0000 pass S, 0001 pass R, 0100 R+S, 0101 R−S
- alu_y  in  16  ALU result
- alu_c  in  1  ALU carry; borrow for 0101
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- div_by_zero  out  1  set on divide with b==0; held until next accepted start
- result_hi  out  16  multiply: product[31:16]; divide: remainder
- result_lo  out  16  multiply: product[15:0]; divide: quotient

## Operation
- Internal registers: acc[15:0], q[15:0], opnd[15:0] (latched b), cnt[4:0], mode (latched op), state.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: alu_r=0, alu_s=0, alu_op=0000.
  - On start: latch mode=op, opnd=b, q=a, acc=0, cnt=0, clear div_by_zero.
  - If op=1 and b==0: skip RUN and go to DONE with div_by_zero=1, result_hi=a, result_lo=16'hFFFF.
  - Otherwise go to RUN.
- RUN, multiply, per cycle: alu_r=acc, alu_s=opnd, alu_op=0100 if q[0]=1, else 0001.
  - Update: acc ← {alu_c, alu_y[15:1]}; q ← {alu_y[0], q[15:1]}.
  - alu_c is forced to 0 under 0001.
- RUN, divide, per cycle: t = {acc[14:0], q[15]}, top = acc[15]; alu_r=t, alu_s=opnd, alu_op=0101.
  - If top=1 or alu_c=0: acc ← alu_y and q ← {q[14:0], 1}.
  - Else: acc ← t and q ← {q[14:0], 0}.
- cnt increments every RUN cycle. The RUN cycle with cnt==15 moves to DONE.
- DONE: done=1. Load result_hi=acc and result_lo=q (or the div-by-zero values), then return to IDLE. alu_* as in IDLE.
- result_hi, result_lo and div_by_zero hold until the next accepted start.
- start in RUN or DONE is ignored; there is no queuing.
- op, a and b are ignored except on the accepted start cycle.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, result_hi=0, result_lo=0, alu_r=0, alu_s=0, alu_op=0000, state=IDLE, cnt=0.
- alu_* outputs are combinational from registered state. The ALU is combinational, so each iteration completes in one clk.
- Start accepted at edge N: RUN during cycles N+1..N+16, done high in cycle N+17, results valid from N+17.
- Divide by zero: done is high in cycle N+1.
- A new start is accepted no earlier than the cycle after done (IDLE). Back-to-back throughput is 18 cycles per operation.
- Reset asserted mid-RUN or in DONE: outputs return immediately to reset values and no done pulse is issued. The operation is lost.
- Arithmetic is unsigned. The multiply carry from alu_c is the 17th bit of each partial sum. The divide uses top to handle the 17-bit transient remainder.

## Test plan
- Multiply a=300 (16'h012C), b=200 (16'h00C8) → done at start+17; hi=16'h0000, lo=16'hEA60; div_by_zero=0.
- Multiply a=16'hFFFF, b=16'hFFFF → hi=16'hFFFE, lo=16'h0001; checks the carry path.
- Divide a=100, b=7 → lo=16'h000E, hi=16'h0002. Divide a=16'hFFFF, b=16'h8001 → lo=1, hi=16'h7FFE; checks top-bit accept.
- Divide a=16'h1234, b=0 → done at start+1, div_by_zero=1, hi=16'h1234, lo=16'hFFFF. The next valid start clears the flag.
- Start a multiply, pulse start with different a/b at start+5 → ignored; the original result is delivered. busy=1 from start+1 through start+17.
- Assert reset at start+8 → busy, done and results are 0 the same cycle and no done pulse follows. After release, a fresh 3×5 multiply gives lo=16'h000F.
